// File: rtl/if_fetch_unit.sv
// if_fetch_unit: instruction-fetch stage owning the PC, running a level-handshake
// instruction-memory read with wait states, and presenting {IF_PC, IF_INSTRUCTION}
// to the IF/ID register through a one-entry skid buffer.
// Ports:
//   CLK, RESET_N          clock, asynchronous active-low reset
//   HOLD                  pipeline stall shared with the IF/ID register
//   BRANCH_TAKEN/TARGET   redirect request from EX (target bits [1:0] ignored)
//   IMEM_ADDR/READ        fetch address (= PC) and level read request
//   IMEM_READDATA/BUSYWAIT instruction data and memory busy flag
//   IF_PC/IF_INSTRUCTION  registered output slot (bubble = {0, NOP_INSTR})
module if_fetch_unit #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
    input  logic        CLK,
    input  logic        RESET_N,
    input  logic        HOLD,
    input  logic        BRANCH_TAKEN,
    input  logic [31:0] BRANCH_TARGET,
    output logic [31:0] IMEM_ADDR,
    output logic        IMEM_READ,
    input  logic [31:0] IMEM_READDATA,
    input  logic        IMEM_BUSYWAIT,
    output logic [31:0] IF_PC,
    output logic [31:0] IF_INSTRUCTION
);
    typedef enum logic [1:0] {FETCH, WAIT_HOLD, DRAIN} state_t;
    state_t state, state_n;
    logic [31:0] pc, pc_n, redirect, redirect_n;
    logic [31:0] sk_pc, sk_pc_n, sk_instr, sk_instr_n;
    logic [31:0] slot_pc_n, slot_instr_n;
    logic [31:0] target;
    logic        done;
    assign IMEM_ADDR = pc;
    assign IMEM_READ = RESET_N & (state != WAIT_HOLD);
    assign done      = IMEM_READ & ~IMEM_BUSYWAIT;
    assign target    = BRANCH_TARGET & ~32'h3;
    always_comb begin
        state_n      = state;
        pc_n         = pc;
        redirect_n   = redirect;
        sk_pc_n      = sk_pc;
        sk_instr_n   = sk_instr;
        // the slot is consumed on every HOLD=0 edge, so it reloads with a bubble unless data arrives
        slot_pc_n    = HOLD ? IF_PC : 32'h0;
        slot_instr_n = HOLD ? IF_INSTRUCTION : NOP_INSTR;
        if (BRANCH_TAKEN) begin
            slot_pc_n    = 32'h0;
            slot_instr_n = NOP_INSTR;
            sk_pc_n      = 32'h0;
            sk_instr_n   = NOP_INSTR;
            case (state)
                FETCH: begin
                    // an outstanding access must finish on its own address before redirecting
                    if (done) pc_n = target;
                    else begin
                        redirect_n = target;
                        state_n    = DRAIN;
                    end
                end
                WAIT_HOLD: begin
                    pc_n    = target;
                    state_n = FETCH;
                end
                DRAIN: begin
                    redirect_n = target;
                    if (done) begin
                        pc_n    = target;
                        state_n = FETCH;
                    end
                end
                default: state_n = FETCH;
            endcase
        end else begin
            case (state)
                FETCH: begin
                    if (done) begin
                        pc_n = pc + 32'd4;
                        if (HOLD) begin
                            sk_pc_n    = pc;
                            sk_instr_n = IMEM_READDATA;
                            state_n    = WAIT_HOLD;
                        end else begin
                            slot_pc_n    = pc;
                            slot_instr_n = IMEM_READDATA;
                        end
                    end
                end
                WAIT_HOLD: begin
                    if (!HOLD) begin
                        slot_pc_n    = sk_pc;
                        slot_instr_n = sk_instr;
                        state_n      = FETCH;
                    end
                end
                DRAIN: begin
                    if (done) begin
                        pc_n    = redirect;
                        state_n = FETCH;
                    end
                end
                default: state_n = FETCH;
            endcase
        end
    end
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state          <= FETCH;
            pc             <= RESET_PC;
            redirect       <= 32'h0;
            sk_pc          <= 32'h0;
            sk_instr       <= NOP_INSTR;
            IF_PC          <= 32'h0;
            IF_INSTRUCTION <= NOP_INSTR;
        end else begin
            state          <= state_n;
            pc             <= pc_n;
            redirect       <= redirect_n;
            sk_pc          <= sk_pc_n;
            sk_instr       <= sk_instr_n;
            IF_PC          <= slot_pc_n;
            IF_INSTRUCTION <= slot_instr_n;
        end
    end
endmodule

// File: tb/tb_if_fetch_unit.sv
// tb_if_fetch_unit: scoreboard bench for if_fetch_unit with a wait-state memory model
// and a second zero-wait instance checking PC wrap-around.
module tb_if_fetch_unit;
    localparam logic [31:0] NOP = 32'h0000_0013;
    logic        CLK = 1'b0;
    logic        RESET_N, HOLD, BRANCH_TAKEN;
    logic [31:0] BRANCH_TARGET;
    logic [31:0] IMEM_ADDR, IMEM_READDATA, IF_PC, IF_INSTRUCTION;
    logic        IMEM_READ, IMEM_BUSYWAIT;
    logic [31:0] addr2, data2, pc2, instr2;
    logic        read2;
    logic        zero = 1'b0;
    logic [31:0] zero32 = 32'h0;
    int          wait_n, cnt, checks, errors, bubbles;
    typedef struct {logic [31:0] pc; int gap;} exp_t;
    exp_t        sb[$];
    logic        prev_busy;
    logic [31:0] prev_addr;

    always #5 CLK = ~CLK;

    function automatic logic [31:0] mem(input logic [31:0] a);
        return {a[15:0], ~a[15:0]} ^ 32'h1357_0000;
    endfunction

    if_fetch_unit #(.RESET_PC(32'h0000_0100)) dut (
        .CLK(CLK), .RESET_N(RESET_N), .HOLD(HOLD), .BRANCH_TAKEN(BRANCH_TAKEN),
        .BRANCH_TARGET(BRANCH_TARGET), .IMEM_ADDR(IMEM_ADDR), .IMEM_READ(IMEM_READ),
        .IMEM_READDATA(IMEM_READDATA), .IMEM_BUSYWAIT(IMEM_BUSYWAIT),
        .IF_PC(IF_PC), .IF_INSTRUCTION(IF_INSTRUCTION));

    if_fetch_unit #(.RESET_PC(32'hFFFF_FFF8)) dut_wrap (
        .CLK(CLK), .RESET_N(RESET_N), .HOLD(zero), .BRANCH_TAKEN(zero),
        .BRANCH_TARGET(zero32), .IMEM_ADDR(addr2), .IMEM_READ(read2),
        .IMEM_READDATA(data2), .IMEM_BUSYWAIT(zero),
        .IF_PC(pc2), .IF_INSTRUCTION(instr2));

    assign data2         = mem(addr2);
    assign IMEM_READDATA = mem(IMEM_ADDR);
    assign IMEM_BUSYWAIT = IMEM_READ && (cnt < wait_n);

    always @(posedge CLK or negedge RESET_N)
        if (!RESET_N) cnt <= 0;
        else if (IMEM_READ && IMEM_BUSYWAIT) cnt <= cnt + 1;
        else cnt <= 0;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic push(input logic [31:0] pc, input int gap);
        exp_t e;
        e.pc  = pc;
        e.gap = gap;
        sb.push_back(e);
    endtask

    // The slot value seen at a negedge with HOLD=0 is what IF/ID captures at the next edge.
    always @(negedge CLK) begin
        if (!RESET_N) begin
            bubbles   = 0;
            prev_busy = 1'b0;
        end else begin
            if (prev_busy) chk("addr_stable", IMEM_ADDR, prev_addr);
            prev_busy = IMEM_READ && IMEM_BUSYWAIT;
            prev_addr = IMEM_ADDR;
            if (!HOLD) begin
                if (IF_PC == 32'h0 && IF_INSTRUCTION == NOP) bubbles++;
                else if (sb.size() == 0) chk("sb_empty", 32'(sb.size()), 32'd1);
                else begin
                    exp_t e;
                    e = sb.pop_front();
                    chk("slot_pc", IF_PC, e.pc);
                    chk("slot_instr", IF_INSTRUCTION, mem(e.pc));
                    if (e.gap >= 0) chk("bubbles", 32'(bubbles), 32'(e.gap));
                    bubbles = 0;
                end
            end
        end
    end

    initial begin
        checks = 0; errors = 0; bubbles = 0; prev_busy = 1'b0; prev_addr = 32'h0;
        RESET_N = 1'b0; HOLD = 1'b0; BRANCH_TAKEN = 1'b0; BRANCH_TARGET = 32'h0; wait_n = 0;
        repeat (3) @(posedge CLK);
        #1;
        chk("rst_read", 32'(IMEM_READ), 32'd0);
        chk("rst_read_wrap", 32'(read2), 32'd0);
        chk("rst_pc", IF_PC, 32'h0);
        chk("rst_instr", IF_INSTRUCTION, NOP);
        chk("rst_addr", IMEM_ADDR, 32'h100);
        push(32'h100, -1); push(32'h104, 0); push(32'h108, 0);
        RESET_N = 1'b1;
        tick();
        chk("wrap_pc0", pc2, 32'hFFFF_FFF8);
        chk("wrap_instr0", instr2, mem(32'hFFFF_FFF8));
        tick();
        chk("wrap_pc1", pc2, 32'hFFFF_FFFC);
        HOLD = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            if (i == 0) begin
                chk("wrap_pc2", pc2, 32'h0);
                chk("wrap_instr2", instr2, mem(32'h0));
            end
            chk("hold_pc", IF_PC, 32'h104);
            chk("hold_instr", IF_INSTRUCTION, mem(32'h104));
            chk("hold_read", 32'(IMEM_READ), 32'd0);
        end
        HOLD = 1'b0;
        push(32'h10C, -1);
        tick();
        chk("release_pc", IF_PC, 32'h108);
        tick();
        wait_n = 2;
        push(32'h110, 2); push(32'h114, 2);
        repeat (6) tick();
        chk("busy_addr", IMEM_ADDR, 32'h118);
        BRANCH_TAKEN = 1'b1; BRANCH_TARGET = 32'h203;
        push(32'h200, 5);
        tick();
        BRANCH_TAKEN = 1'b0;
        chk("drain_addr", IMEM_ADDR, 32'h118);
        chk("drain_read", 32'(IMEM_READ), 32'd1);
        chk("drain_slot", IF_INSTRUCTION, NOP);
        tick();
        chk("drain_addr2", IMEM_ADDR, 32'h118);
        tick();
        chk("target_addr", IMEM_ADDR, 32'h200);
        repeat (3) tick();
        wait_n = 0;
        tick();
        HOLD = 1'b1;
        tick();
        chk("wh_read", 32'(IMEM_READ), 32'd0);
        chk("wh_pc", IF_PC, 32'h204);
        BRANCH_TAKEN = 1'b1; BRANCH_TARGET = 32'h300;
        push(32'h300, 1); push(32'h304, 0); push(32'h308, 0);
        tick();
        chk("wh_br_slot", IF_INSTRUCTION, NOP);
        chk("wh_br_addr", IMEM_ADDR, 32'h300);
        BRANCH_TAKEN = 1'b0; HOLD = 1'b0;
        repeat (3) tick();
        wait_n = 2;
        tick();
        #3 RESET_N = 1'b0;
        #1;
        chk("mid_rst_pc", IF_PC, 32'h0);
        chk("mid_rst_instr", IF_INSTRUCTION, NOP);
        chk("mid_rst_read", 32'(IMEM_READ), 32'd0);
        chk("mid_rst_addr", IMEM_ADDR, 32'h100);
        chk("mid_rst_wrap", instr2, NOP);
        repeat (2) tick();
        chk("sb_left", 32'(sb.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
